draw_cmd_decoder: RTL and testbench
===================================

Name: draw_cmd_decoder

Overview:
Upstream command front-end for the drawing engines. It assembles a 5-byte command (opcode, x0, y0, x1, y1) from an 8-bit byte stream. It then issues a one-cycle start to the selected engine (filled rectangle or line) and holds the coordinates stable until that engine reports done. It also provides inter-byte timeout recovery and bad-opcode reporting.

Parameters:
GAP_TIMEOUT, 255, max idle clk cycles allowed between argument bytes before the partial command is dropped (1..65535)
TO_W, 16, width of the gap-timeout counter; must hold GAP_TIMEOUT

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
byte_in  in  8  command/argument byte
byte_valid  in  1  byte_in valid; a byte is accepted on a cycle with byte_valid && byte_ready
byte_ready  out  1  decoder can accept a byte
eng_done  in  1  one-cycle done pulse from the engine currently dispatched
start_fill  out  1  one-cycle start to the rectangle-fill engine
start_line  out  1  one-cycle start to the line engine
x0  out  8  corner/endpoint A x
y0  out  8  corner/endpoint A y
x1  out  8  corner/endpoint B x
y1  out  8  corner/endpoint B y
busy  out  1  a command is being assembled or executed
cmd_done  out  1  one-cycle pulse when the dispatched engine finishes
err  out  1  one-cycle pulse on bad opcode or gap timeout

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; internal arg index and gap counter 0. Reset mid-command discards it. No start pulse is emitted after reset is released until a new complete command arrives.
- Opcodes: 0x00 NOP, accepted and ignored with no pulses. 0x01 FILL. 0x02 LINE. 0x03 PIXEL, which takes 2 arg bytes (x0, y0), forces x1=x0 and y1=y0, and dispatches to fill. Any other value makes err pulse for 1 cycle the cycle after acceptance; state stays IDLE.
- States:
  - IDLE: byte_ready=1, busy=0. An accepted valid opcode latches the opcode, clears the index and gap counter, and moves to ARGS.
  - ARGS: byte_ready=1, busy=1. Accepted bytes fill x0, y0, x1, y1 in order; needed count is 4, or 2 for PIXEL. The gap counter clears on each accepted byte, otherwise increments. On the last accepted arg byte, go to DISPATCH. If the counter reaches GAP_TIMEOUT with no byte: err pulse, back to IDLE, and coordinate outputs retain their old values.
  - DISPATCH: exactly 1 cycle, byte_ready=0. Assert start_fill (FILL/PIXEL) or start_line (LINE) for that cycle only, then go to WAIT. Never assert both starts at once.
  - WAIT: byte_ready=0, busy=1. x0..y1 are held stable because engines latch them after start. On eng_done: cmd_done pulses the next cycle, and the state returns to IDLE. eng_done seen in any other state is ignored.
- Latency: last arg byte accepted at cycle N means the start pulse is high in cycle N+1. eng_done at cycle M means cmd_done is high in cycle M+1, with byte_ready=1 from cycle M+1.
- busy deasserts in the same cycle cmd_done asserts.
- Back-to-back commands: the next opcode can be accepted in the cycle cmd_done is high.
- byte_valid while byte_ready=0: the byte is not consumed; the source must hold it.
- Coordinates are raw 8-bit values; no ordering or clipping is applied here (engines order min/max).

Test Plan:
- FILL: bytes 01,0A,14,0C,15 back-to-back -> start_fill high exactly 1 cycle after byte 5, x0=0x0A y0=0x14 x1=0x0C y1=0x15 held; eng_done 3 cycles later -> cmd_done 1 cycle later, busy drops.
- PIXEL: 03,07,09 -> start_fill after byte 3 with x0=x1=0x07 and y0=y1=0x09; start_line stays 0 throughout.
- Bad opcode 0x55 -> err pulse 1 cycle, no start, busy=0; following 02,00,00,FF,FF -> start_line and correct coords.
- Gap timeout (GAP_TIMEOUT=4): 01,10,20 then 5 idle cycles -> err pulse, state IDLE, no start; a new full command then executes normally.
- Backpressure: hold byte_valid=1 with opcode 01 during WAIT -> byte_ready=0 and the byte is not consumed; it is accepted the cycle cmd_done pulses.
- Reset mid-ARGS (after 01,05) -> all outputs 0; following 00 NOP -> no pulses, busy stays 0.

Source files
------------

// File: rtl/draw_cmd_decoder_if.sv
// Byte-stream command bus plus engine dispatch signals for draw_cmd_decoder.
// slave is the decoder side; master is the byte source / engine side.
interface draw_cmd_decoder_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       eng_done;
  logic       start_fill;
  logic       start_line;
  logic [7:0] x0;
  logic [7:0] y0;
  logic [7:0] x1;
  logic [7:0] y1;
  logic       busy;
  logic       cmd_done;
  logic       err;

  modport master (
    output byte_in, byte_valid, eng_done,
    input  byte_ready, start_fill, start_line,
    input  x0, y0, x1, y1,
    input  busy, cmd_done, err
  );

  modport slave (
    input  byte_in, byte_valid, eng_done,
    output byte_ready, start_fill, start_line,
    output x0, y0, x1, y1,
    output busy, cmd_done, err
  );
endinterface

// File: rtl/draw_cmd_decoder.sv
// Assembles opcode+coordinate commands from a byte stream and dispatches them
// to the fill or line engine, holding coordinates until the engine is done.
module draw_cmd_decoder #(
  parameter int GAP_TIMEOUT = 255,
  parameter int TO_W        = 16
) (
  input logic               clk,
  input logic               rst_n,
  draw_cmd_decoder_if.slave bus
);

  localparam logic [TO_W-1:0] GAP_LIMIT = TO_W'(GAP_TIMEOUT);
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_FILL  = 8'h01;
  localparam logic [7:0] OP_LINE  = 8'h02;
  localparam logic [7:0] OP_PIXEL = 8'h03;

  typedef enum logic [1:0] {
    IDLE,
    ARGS,
    DISPATCH,
    WAIT
  } state_t;

  state_t          state;
  logic [7:0]      opcode;
  logic [1:0]      arg_idx;
  logic [TO_W-1:0] gap_cnt;
  logic [7:0]      arg_x0;
  logic [7:0]      arg_y0;
  logic [7:0]      arg_x1;
  logic            accept;
  logic            is_pixel;
  logic            last_arg;

  assign accept   = bus.byte_valid && bus.byte_ready;
  assign is_pixel = (opcode == OP_PIXEL);
  assign last_arg = is_pixel ? (arg_idx == 2'd1) : (arg_idx == 2'd3);

  // Arguments collect in shadow registers and only reach x0..y1 on the final
  // byte, so a dropped partial command leaves the previous coordinates intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      opcode         <= 8'h00;
      arg_idx        <= 2'd0;
      gap_cnt        <= '0;
      arg_x0         <= 8'h00;
      arg_y0         <= 8'h00;
      arg_x1         <= 8'h00;
      bus.byte_ready <= 1'b0;
      bus.start_fill <= 1'b0;
      bus.start_line <= 1'b0;
      bus.x0         <= 8'h00;
      bus.y0         <= 8'h00;
      bus.x1         <= 8'h00;
      bus.y1         <= 8'h00;
      bus.busy       <= 1'b0;
      bus.cmd_done   <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.start_fill <= 1'b0;
      bus.start_line <= 1'b0;
      bus.cmd_done   <= 1'b0;
      bus.err        <= 1'b0;

      case (state)
        IDLE: begin
          bus.byte_ready <= 1'b1;
          bus.busy       <= 1'b0;
          if (accept) begin
            case (bus.byte_in)
              OP_NOP: begin
              end
              OP_FILL, OP_LINE, OP_PIXEL: begin
                opcode   <= bus.byte_in;
                arg_idx  <= 2'd0;
                gap_cnt  <= '0;
                bus.busy <= 1'b1;
                state    <= ARGS;
              end
              default: bus.err <= 1'b1;
            endcase
          end
        end

        ARGS: begin
          if (accept) begin
            gap_cnt <= '0;
            case (arg_idx)
              2'd0:    arg_x0 <= bus.byte_in;
              2'd1:    arg_y0 <= bus.byte_in;
              2'd2:    arg_x1 <= bus.byte_in;
              default: begin
              end
            endcase
            if (last_arg) begin
              bus.x0         <= arg_x0;
              bus.y0         <= is_pixel ? bus.byte_in : arg_y0;
              bus.x1         <= is_pixel ? arg_x0 : arg_x1;
              bus.y1         <= bus.byte_in;
              bus.start_fill <= (opcode != OP_LINE);
              bus.start_line <= (opcode == OP_LINE);
              bus.byte_ready <= 1'b0;
              state          <= DISPATCH;
            end else begin
              arg_idx <= arg_idx + 2'd1;
            end
          end else if (gap_cnt == GAP_LIMIT) begin
            // A byte arriving on the limit cycle still wins over the timeout.
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
            gap_cnt  <= '0;
            arg_idx  <= 2'd0;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + TO_W'(1);
          end
        end

        DISPATCH: begin
          state <= WAIT;
        end

        WAIT: begin
          if (bus.eng_done) begin
            bus.cmd_done   <= 1'b1;
            bus.busy       <= 1'b0;
            bus.byte_ready <= 1'b1;
            state          <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_cmd_decoder.sv
// Randomized self-checking bench for draw_cmd_decoder; expected behaviour
// comes from a command-level model of opcode rules and cycle latencies.
module tb_draw_cmd_decoder;

  localparam int GAP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  draw_cmd_decoder_if bus ();

  draw_cmd_decoder #(
    .GAP_TIMEOUT(GAP),
    .TO_W       (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int fill_cycles = 0;
  int line_cycles = 0;
  int err_cycles = 0;
  int done_cycles = 0;
  int both_cycles = 0;
  logic [31:0] last_xy = 32'h0;

  // Pulse counters let scenarios check pulse totals, not just sampled cycles.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.start_fill) fill_cycles++;
      if (bus.start_line) line_cycles++;
      if (bus.err) err_cycles++;
      if (bus.cmd_done) done_cycles++;
      if (bus.start_fill && bus.start_line) both_cycles++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int arg_count(input logic [7:0] op);
    case (op)
      8'h01, 8'h02: return 4;
      8'h03:        return 2;
      default:      return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_xy(input logic [7:0] op,
                                           input logic [7:0] a0, a1, a2, a3);
    return (op == 8'h03) ? {a0, a1, a0, a1} : {a0, a1, a2, a3};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input int gap);
    int n;
    bus.byte_valid = 1'b0;
    repeat (gap) tick();
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    n = 0;
    while (bus.byte_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL push_timeout: byte_ready got %b required 1", bus.byte_ready);
    end
    tick();
    bus.byte_valid = 1'b0;
  endtask

  // Entered in the cycle after the opcode was accepted.
  task automatic run_args(input logic [7:0] op, input logic [7:0] a0, a1, a2, a3,
                          input int gap, input int dly, input string name);
    logic [7:0]  args[4];
    logic [31:0] exp_xy;
    logic [1:0]  exp_start;
    int          n;
    args = '{a0, a1, a2, a3};
    n = arg_count(op);
    exp_xy = model_xy(op, a0, a1, a2, a3);
    exp_start = (op == 8'h02) ? 2'b01 : 2'b10;
    for (int i = 0; i < n; i++)
      push_byte(args[i], (gap < 0) ? int'($urandom_range(0, GAP)) : gap);
    vectors++;
    if ({bus.start_fill, bus.start_line} !== exp_start) begin
      miscompares++;
      $display("[TB] FAIL %s start: got %b required %b", name,
               {bus.start_fill, bus.start_line}, exp_start);
    end
    vectors++;
    if ({bus.x0, bus.y0, bus.x1, bus.y1} !== exp_xy) begin
      miscompares++;
      $display("[TB] FAIL %s coords: got %h required %h", name,
               {bus.x0, bus.y0, bus.x1, bus.y1}, exp_xy);
    end
    vectors++;
    if ({bus.busy, bus.byte_ready} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL %s dispatch_flags: got %b required 10", name,
               {bus.busy, bus.byte_ready});
    end
    tick();
    vectors++;
    if ({bus.start_fill, bus.start_line} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL %s start_width: got %b required 00", name,
               {bus.start_fill, bus.start_line});
    end
    for (int i = 0; i < dly; i++) begin
      vectors++;
      if ({bus.x0, bus.y0, bus.x1, bus.y1, bus.busy, bus.byte_ready} !== {exp_xy, 2'b10}) begin
        miscompares++;
        $display("[TB] FAIL %s wait_hold: got %h/%b required %h/10", name,
                 {bus.x0, bus.y0, bus.x1, bus.y1}, {bus.busy, bus.byte_ready}, exp_xy);
      end
      tick();
    end
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    vectors++;
    if ({bus.cmd_done, bus.busy, bus.byte_ready} !== 3'b101) begin
      miscompares++;
      $display("[TB] FAIL %s cmd_done: got %b required 101", name,
               {bus.cmd_done, bus.busy, bus.byte_ready});
    end
    vectors++;
    if ({bus.x0, bus.y0, bus.x1, bus.y1} !== exp_xy) begin
      miscompares++;
      $display("[TB] FAIL %s coords_after_done: got %h required %h", name,
               {bus.x0, bus.y0, bus.x1, bus.y1}, exp_xy);
    end
    last_xy = exp_xy;
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [7:0] a0, a1, a2, a3,
                         input int gap, input int dly, input string name);
    logic exp_err;
    push_byte(op, (gap < 0) ? int'($urandom_range(0, GAP)) : gap);
    if (arg_count(op) == 0) begin
      exp_err = (op != 8'h00);
      vectors++;
      if ({bus.err, bus.busy, bus.start_fill, bus.start_line} !== {exp_err, 3'b000}) begin
        miscompares++;
        $display("[TB] FAIL %s opcode_reject: got %b required %b", name,
                 {bus.err, bus.busy, bus.start_fill, bus.start_line}, {exp_err, 3'b000});
      end
    end else begin
      run_args(op, a0, a1, a2, a3, gap, dly, name);
    end
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({bus.byte_ready, bus.start_fill, bus.start_line, bus.busy, bus.cmd_done, bus.err} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b required 000000",
               {bus.byte_ready, bus.start_fill, bus.start_line, bus.busy, bus.cmd_done, bus.err});
    end
    vectors++;
    if ({bus.x0, bus.y0, bus.x1, bus.y1} !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_coords: got %h required 00000000",
               {bus.x0, bus.y0, bus.x1, bus.y1});
    end
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if ({bus.byte_ready, bus.busy} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got %b required 10", {bus.byte_ready, bus.busy});
    end
  endtask

  task automatic test_fill();
    int l0;
    l0 = line_cycles;
    run_cmd(8'h01, 8'h0A, 8'h14, 8'h0C, 8'h15, 0, 2, "fill");
    vectors++;
    if (line_cycles !== l0) begin
      miscompares++;
      $display("[TB] FAIL fill_no_line: got %0d required %0d", line_cycles, l0);
    end
  endtask

  task automatic test_pixel();
    int l0, f0;
    l0 = line_cycles;
    f0 = fill_cycles;
    run_cmd(8'h03, 8'h07, 8'h09, 8'h00, 8'h00, 0, 1, "pixel");
    vectors++;
    if ({line_cycles - l0, fill_cycles - f0} !== {32'd0, 32'd1}) begin
      miscompares++;
      $display("[TB] FAIL pixel_pulses: got line %0d fill %0d required 0 1",
               line_cycles - l0, fill_cycles - f0);
    end
  endtask

  task automatic test_bad_opcode();
    int f0;
    f0 = fill_cycles + line_cycles;
    run_cmd(8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, "bad_op");
    tick();
    vectors++;
    if ({bus.err, bus.busy} !== 2'b00 || fill_cycles + line_cycles !== f0) begin
      miscompares++;
      $display("[TB] FAIL bad_op_after: got err/busy %b starts %0d required 00 %0d",
               {bus.err, bus.busy}, fill_cycles + line_cycles, f0);
    end
    run_cmd(8'h02, 8'h00, 8'h00, 8'hFF, 8'hFF, 0, 0, "line_after_bad");
  endtask

  task automatic test_timeout();
    int s0;
    s0 = fill_cycles + line_cycles;
    push_byte(8'h01, 0);
    push_byte(8'h10, 0);
    push_byte(8'h20, 0);
    // GAP idle cycles are tolerated; the timeout fires after one more.
    for (int i = 1; i <= GAP + 1; i++) begin
      vectors++;
      if ({bus.err, bus.busy, bus.byte_ready} !== 3'b011) begin
        miscompares++;
        $display("[TB] FAIL timeout_early idle %0d: got %b required 011", i,
                 {bus.err, bus.busy, bus.byte_ready});
      end
      tick();
    end
    vectors++;
    if ({bus.err, bus.busy, bus.byte_ready} !== 3'b101) begin
      miscompares++;
      $display("[TB] FAIL timeout_err: got %b required 101", {bus.err, bus.busy, bus.byte_ready});
    end
    vectors++;
    if ({bus.x0, bus.y0, bus.x1, bus.y1} !== last_xy || fill_cycles + line_cycles !== s0) begin
      miscompares++;
      $display("[TB] FAIL timeout_retain: got %h starts %0d required %h %0d",
               {bus.x0, bus.y0, bus.x1, bus.y1}, fill_cycles + line_cycles, last_xy, s0);
    end
    run_cmd(8'h02, 8'h31, 8'h32, 8'h33, 8'h34, GAP, 1, "max_gap_line");
    run_cmd(8'h01, 8'h41, 8'h42, 8'h43, 8'h44, 0, 0, "after_timeout");
  endtask

  task automatic test_backpressure();
    push_byte(8'h01, 0);
    push_byte(8'h01, 0);
    push_byte(8'h02, 0);
    push_byte(8'h03, 0);
    push_byte(8'h04, 0);
    vectors++;
    if (bus.start_fill !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_start: got %b required 1", bus.start_fill);
    end
    bus.byte_in = 8'h01;
    bus.byte_valid = 1'b1;
    tick();
    repeat (3) begin
      vectors++;
      if ({bus.byte_ready, bus.busy} !== 2'b01) begin
        miscompares++;
        $display("[TB] FAIL bp_hold: got %b required 01", {bus.byte_ready, bus.busy});
      end
      tick();
    end
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    vectors++;
    if ({bus.cmd_done, bus.byte_ready, bus.busy} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL bp_done: got %b required 110", {bus.cmd_done, bus.byte_ready, bus.busy});
    end
    tick();
    bus.byte_valid = 1'b0;
    vectors++;
    if ({bus.cmd_done, bus.byte_ready, bus.busy} !== 3'b011) begin
      miscompares++;
      $display("[TB] FAIL bp_accepted: got %b required 011", {bus.cmd_done, bus.byte_ready, bus.busy});
    end
    run_args(8'h01, 8'h21, 8'h22, 8'h23, 8'h24, 0, 1, "bp_next");
  endtask

  task automatic test_eng_done_ignored();
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    repeat (2) begin
      vectors++;
      if ({bus.cmd_done, bus.busy} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL stray_done: got %b required 00", {bus.cmd_done, bus.busy});
      end
      tick();
    end
  endtask

  task automatic test_random();
    int f0, l0, e0, d0, ef, el, ee, ed, r;
    logic [7:0] op;
    f0 = fill_cycles; l0 = line_cycles; e0 = err_cycles; d0 = done_cycles;
    ef = 0; el = 0; ee = 0; ed = 0;
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) op = 8'h00;
      else if (r == 1) op = 8'($urandom_range(4, 255));
      else if (r <= 4) op = 8'h01;
      else if (r <= 7) op = 8'h02;
      else op = 8'h03;
      if (op == 8'h01 || op == 8'h03) ef++;
      if (op == 8'h02) el++;
      if (op > 8'h03) ee++;
      if (arg_count(op) > 0) ed++;
      run_cmd(op, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              -1, int'($urandom_range(0, 4)), "random");
    end
    tick();
    tick();
    vectors++;
    if ({fill_cycles - f0, line_cycles - l0} !== {ef, el}) begin
      miscompares++;
      $display("[TB] FAIL random_starts: got fill %0d line %0d required %0d %0d",
               fill_cycles - f0, line_cycles - l0, ef, el);
    end
    vectors++;
    if ({err_cycles - e0, done_cycles - d0} !== {ee, ed}) begin
      miscompares++;
      $display("[TB] FAIL random_err_done: got err %0d done %0d required %0d %0d",
               err_cycles - e0, done_cycles - d0, ee, ed);
    end
  endtask

  task automatic test_reset_mid_args();
    push_byte(8'h01, 0);
    push_byte(8'h05, 0);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.byte_ready, bus.start_fill, bus.start_line, bus.busy, bus.cmd_done, bus.err,
         bus.x0, bus.y0, bus.x1, bus.y1} !== 38'h0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got %b/%h required all zero",
               {bus.byte_ready, bus.start_fill, bus.start_line, bus.busy, bus.cmd_done, bus.err},
               {bus.x0, bus.y0, bus.x1, bus.y1});
    end
    tick();
    rst_n = 1'b1;
    push_byte(8'h00, 0);
    repeat (4) begin
      vectors++;
      if ({bus.busy, bus.err, bus.start_fill, bus.start_line, bus.cmd_done} !== 5'b0) begin
        miscompares++;
        $display("[TB] FAIL nop_after_reset: got %b required 00000",
                 {bus.busy, bus.err, bus.start_fill, bus.start_line, bus.cmd_done});
      end
      tick();
    end
  endtask

  initial begin
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;
    bus.eng_done = 1'b0;
    test_reset();
    test_fill();
    test_pixel();
    test_bad_opcode();
    test_timeout();
    test_backpressure();
    test_eng_done_ignored();
    test_random();
    test_reset_mid_args();
    vectors++;
    if (both_cycles !== 0) begin
      miscompares++;
      $display("[TB] FAIL both_starts: got %0d cycles required 0", both_cycles);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
